// File: rtl/dau_serial_stack_pkg.sv
// Shared definitions for the digit-serial RPN decimal arithmetic unit.
// Holds the key/display symbol codes (also used by the keypad and display
// blocks), the controller state and action encodings, and small helpers.
package dau_serial_stack_pkg;

   localparam int DAU_SYM_WIDTH = 5;

   typedef logic [DAU_SYM_WIDTH-1:0] sym_t;

   // Digit keys are codes 0..9 (SYM_D0..SYM_D9).
   localparam sym_t SYM_D9    = 5'd9;
   localparam sym_t SYM_ADD   = 5'd10;
   localparam sym_t SYM_SUB   = 5'd11;
   localparam sym_t SYM_ENTER = 5'd12;
   localparam sym_t SYM_DROP  = 5'd13;
   localparam sym_t SYM_SWAP  = 5'd14;
   localparam sym_t SYM_CLEAR = 5'd15;
   localparam sym_t SYM_NEG   = 5'd16;
   localparam sym_t SYM_ERR   = 5'd17;
   localparam sym_t SYM_EOL   = 5'd18;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXEC,
      ST_RECOMP,
      ST_SHOW_SIGN,
      ST_SHOW_DIG,
      ST_SHOW_EOL,
      ST_SHOW_ERR
   } state_t;

   // Stack/datapath update requested by the controller for this cycle.
   typedef enum logic [3:0] {
      ACT_NONE,
      ACT_PUSH,
      ACT_SHIFT,
      ACT_ENTER,
      ACT_DROP,
      ACT_SWAP,
      ACT_CLEAR,
      ACT_LOAD,
      ACT_COMMIT
   } act_t;

   function automatic logic is_digit(input sym_t s);
      return (s <= SYM_D9);
   endfunction

   // A display sequence starts with the sign symbol only for negative tops.
   function automatic state_t show_entry(input logic neg);
      return neg ? ST_SHOW_SIGN : ST_SHOW_DIG;
   endfunction

endpackage

// File: rtl/dau_serial_stack_if.sv
// Key-in / display-out bus of the RPN decimal arithmetic unit.
//   i_valid, i_symbol       key symbol offered by the keypad side
//   o_ready                 unit can take a symbol (transfer on valid && ready)
//   o_symbol, o_symbol_valid display symbol stream, no backpressure
//   o_depth                 number of occupied stack entries
//   o_error                 one-cycle pulse alongside the ERR symbol
// master: keypad/display side.  slave: the arithmetic unit.
interface dau_serial_stack_if #(
   parameter int STACK_DEPTH = 7
);
   localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

   logic                                            i_valid;
   logic [dau_serial_stack_pkg::DAU_SYM_WIDTH-1:0]  i_symbol;
   logic                                            o_ready;
   logic [dau_serial_stack_pkg::DAU_SYM_WIDTH-1:0]  o_symbol;
   logic                                            o_symbol_valid;
   logic [DEPTH_W-1:0]                              o_depth;
   logic                                            o_error;

   modport master (
      output i_valid,
      output i_symbol,
      input  o_ready,
      input  o_symbol,
      input  o_symbol_valid,
      input  o_depth,
      input  o_error
   );

   modport slave (
      input  i_valid,
      input  i_symbol,
      output o_ready,
      output o_symbol,
      output o_symbol_valid,
      output o_depth,
      output o_error
   );

endinterface

// File: rtl/dau_serial_stack_bcd_digit_alu.sv
// Single BCD digit adder/subtractor (combinational).
//   a, b   BCD digits (0..9)
//   cin    carry in (add) or borrow in (sub)
//   sub    0: a + b + cin, 1: a - b - cin
//   digit  BCD result digit
//   cout   decimal carry out (add) or borrow out (sub)
module bcd_digit_alu (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   input  logic       sub,
   output logic [3:0] digit,
   output logic       cout
);

   logic [4:0] sum;
   logic [4:0] diff;
   logic [4:0] adj;

   always_comb begin
      sum   = {1'b0, a} + {1'b0, b} + {4'b0, cin};
      diff  = {1'b0, a} - {1'b0, b} - {4'b0, cin};
      adj   = 5'd0;
      cout  = 1'b0;
      if (sub) begin
         // Negative difference wraps in 5 bits; adding ten gives the borrowed digit.
         if (diff[4]) begin
            adj  = diff + 5'd10;
            cout = 1'b1;
         end else begin
            adj = diff;
         end
      end else begin
         if (sum > 5'd9) begin
            adj  = sum - 5'd10;
            cout = 1'b1;
         end else begin
            adj = sum;
         end
      end
      digit = adj[3:0];
   end

endmodule

// File: rtl/dau_serial_stack.sv
// Digit-serial RPN decimal arithmetic unit with an internal operand stack.
// Accepts key symbols, runs sign-magnitude BCD add/subtract one digit per
// cycle, and after each accepted symbol streams the top of stack to the
// display (optional NEG, NUM_DIGITS digits MSD first, EOL) or ERR, EOL.
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      key/display bus (slave side), see dau_serial_stack_if
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | ready for a key symbol
// EXEC        | Y op X magnitude, one digit per cycle, LSD first
// RECOMP      | tens' complement of a borrowed difference, sign inverted
// SHOW_SIGN   | emit NEG for a negative top entry
// SHOW_DIG    | emit top entry digits, MSD first
// SHOW_EOL    | emit EOL, back to IDLE
// SHOW_ERR    | emit ERR with o_error, then EOL
module dau_serial_stack
   import dau_serial_stack_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int STACK_DEPTH = 7
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   dau_serial_stack_if.slave bus
);

   localparam int MAG_W   = 4 * NUM_DIGITS;
   localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W   = $clog2(STACK_DEPTH);
   localparam int CNT_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DCNT_W  = $clog2(NUM_DIGITS + 1);

   localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(NUM_DIGITS - 1);
   localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);
   localparam logic [DEPTH_W-1:0] DEPTH_TWO  = DEPTH_W'(2);
   localparam logic [DCNT_W-1:0]  DCNT_FULL  = DCNT_W'(NUM_DIGITS);

   state_t               state_q, state_d;
   act_t                 act;

   logic [MAG_W-1:0]     mag_q  [STACK_DEPTH];
   logic                 sign_q [STACK_DEPTH];
   logic [DEPTH_W-1:0]   depth_q;
   logic                 entry_active_q;
   logic [DCNT_W-1:0]    dig_cnt_q;
   logic [CNT_W-1:0]     cnt_q;

   logic [MAG_W-1:0]     op_y_q, op_x_q, res_q;
   logic                 carry_q, eff_add_q, y_sign_q;

   logic [IDX_W-1:0]     top_idx, sec_idx, push_idx;
   logic [MAG_W-1:0]     top_mag, sec_mag, shift_mag;
   logic                 top_sign, sec_sign;

   logic [3:0]           alu_a, alu_b, alu_digit, key_digit;
   logic                 alu_sub, alu_cout;
   logic [MAG_W+3:0]     res_cat;
   logic [MAG_W-1:0]     res_full, show_sel;
   logic                 commit_sign, load_eff_add;

   // Stack views and digit-serial datapath
   always_comb begin
      top_idx   = IDX_W'(depth_q - 1'b1);
      sec_idx   = IDX_W'(depth_q - DEPTH_TWO);
      push_idx  = IDX_W'(depth_q);
      top_mag   = (depth_q != '0) ? mag_q[top_idx] : '0;
      top_sign  = (depth_q != '0) ? sign_q[top_idx] : 1'b0;
      sec_mag   = (depth_q >= DEPTH_TWO) ? mag_q[sec_idx] : '0;
      sec_sign  = (depth_q >= DEPTH_TWO) ? sign_q[sec_idx] : 1'b0;
      key_digit = bus.i_symbol[3:0];
      shift_mag = (top_mag << 4) | MAG_W'(key_digit);

      // RECOMP computes 0 - result through the same digit cell.
      alu_a   = (state_q == ST_RECOMP) ? 4'd0 : op_y_q[3:0];
      alu_b   = (state_q == ST_RECOMP) ? res_q[3:0] : op_x_q[3:0];
      alu_sub = (state_q == ST_RECOMP) | ~eff_add_q;

      res_cat  = {alu_digit, res_q};
      res_full = res_cat[MAG_W+3:4];

      // Zero results are always stored positive.
      commit_sign = (res_full == '0) ? 1'b0 :
                    ((state_q == ST_RECOMP) ? ~y_sign_q : y_sign_q);

      show_sel = top_mag >> {cnt_q, 2'b00};
   end

   bcd_digit_alu u_alu (
      .a     (alu_a),
      .b     (alu_b),
      .cin   (carry_q),
      .sub   (alu_sub),
      .digit (alu_digit),
      .cout  (alu_cout)
   );

   // Next state, stack action and display outputs
   always_comb begin
      state_d            = state_q;
      act                = ACT_NONE;
      load_eff_add       = 1'b0;
      bus.o_ready        = 1'b0;
      bus.o_symbol_valid = 1'b0;
      bus.o_symbol       = '0;
      bus.o_error        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            bus.o_ready = 1'b1;
            if (bus.i_valid) begin
               if (is_digit(bus.i_symbol)) begin
                  if (!entry_active_q) begin
                     if (depth_q == DEPTH_FULL) begin
                        state_d = ST_SHOW_ERR;
                     end else begin
                        act     = ACT_PUSH;
                        state_d = show_entry(1'b0);
                     end
                  end else begin
                     // Digits past a full entry are dropped but still redisplay.
                     if (dig_cnt_q != DCNT_FULL) act = ACT_SHIFT;
                     state_d = show_entry(top_sign);
                  end
               end else begin
                  case (bus.i_symbol)
                     SYM_ENTER: begin
                        act     = ACT_ENTER;
                        state_d = show_entry(top_sign);
                     end
                     SYM_DROP: begin
                        if (depth_q == '0) begin
                           state_d = ST_SHOW_ERR;
                        end else begin
                           act     = ACT_DROP;
                           state_d = show_entry(sec_sign);
                        end
                     end
                     SYM_SWAP: begin
                        if (depth_q < DEPTH_TWO) begin
                           state_d = ST_SHOW_ERR;
                        end else begin
                           act     = ACT_SWAP;
                           state_d = show_entry(sec_sign);
                        end
                     end
                     SYM_CLEAR: begin
                        act     = ACT_CLEAR;
                        state_d = show_entry(1'b0);
                     end
                     SYM_ADD, SYM_SUB: begin
                        if (depth_q < DEPTH_TWO) begin
                           state_d = ST_SHOW_ERR;
                        end else begin
                           act          = ACT_LOAD;
                           load_eff_add = (sec_sign == top_sign) ^ (bus.i_symbol == SYM_SUB);
                           state_d      = ST_EXEC;
                        end
                     end
                     default: ;
                  endcase
               end
            end
         end
         ST_EXEC: begin
            if (cnt_q == '0) begin
               if (alu_cout && eff_add_q) begin
                  state_d = ST_SHOW_ERR;
               end else if (alu_cout) begin
                  state_d = ST_RECOMP;
               end else begin
                  act     = ACT_COMMIT;
                  state_d = show_entry(commit_sign);
               end
            end
         end
         ST_RECOMP: begin
            if (cnt_q == '0) begin
               act     = ACT_COMMIT;
               state_d = show_entry(commit_sign);
            end
         end
         ST_SHOW_SIGN: begin
            bus.o_symbol_valid = 1'b1;
            bus.o_symbol       = SYM_NEG;
            state_d            = ST_SHOW_DIG;
         end
         ST_SHOW_DIG: begin
            bus.o_symbol_valid = 1'b1;
            bus.o_symbol       = {1'b0, show_sel[3:0]};
            if (cnt_q == '0) state_d = ST_SHOW_EOL;
         end
         ST_SHOW_EOL: begin
            bus.o_symbol_valid = 1'b1;
            bus.o_symbol       = SYM_EOL;
            state_d            = ST_IDLE;
         end
         ST_SHOW_ERR: begin
            bus.o_symbol_valid = 1'b1;
            bus.o_symbol       = SYM_ERR;
            bus.o_error        = 1'b1;
            state_d            = ST_SHOW_EOL;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.o_depth = depth_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         depth_q        <= '0;
         entry_active_q <= 1'b0;
         dig_cnt_q      <= '0;
         op_y_q         <= '0;
         op_x_q         <= '0;
         res_q          <= '0;
         carry_q        <= 1'b0;
         eff_add_q      <= 1'b0;
         y_sign_q       <= 1'b0;
         for (int i = 0; i < STACK_DEPTH; i++) begin
            mag_q[i]  <= '0;
            sign_q[i] <= 1'b0;
         end
      end else begin
         state_q <= state_d;

         // Per-state down-counter: reloads on every state change.
         if (state_d != state_q) begin
            cnt_q <= CNT_LAST;
         end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
         end

         if (state_q == ST_EXEC || state_q == ST_RECOMP) begin
            res_q  <= res_full;
            op_y_q <= op_y_q >> 4;
            op_x_q <= op_x_q >> 4;
            // The complement pass starts with no borrow.
            carry_q <= (state_q == ST_EXEC && state_d == ST_RECOMP) ? 1'b0 : alu_cout;
         end

         case (act)
            ACT_PUSH: begin
               mag_q[push_idx]  <= MAG_W'(key_digit);
               sign_q[push_idx] <= 1'b0;
               depth_q          <= depth_q + 1'b1;
               entry_active_q   <= 1'b1;
               dig_cnt_q        <= DCNT_W'(1);
            end
            ACT_SHIFT: begin
               mag_q[top_idx] <= shift_mag;
               dig_cnt_q      <= dig_cnt_q + 1'b1;
            end
            ACT_ENTER: begin
               entry_active_q <= 1'b0;
            end
            ACT_DROP: begin
               depth_q        <= depth_q - 1'b1;
               entry_active_q <= 1'b0;
            end
            ACT_SWAP: begin
               mag_q[top_idx]  <= sec_mag;
               sign_q[top_idx] <= sec_sign;
               mag_q[sec_idx]  <= top_mag;
               sign_q[sec_idx] <= top_sign;
               entry_active_q  <= 1'b0;
            end
            ACT_CLEAR: begin
               depth_q        <= '0;
               entry_active_q <= 1'b0;
            end
            ACT_LOAD: begin
               op_y_q         <= sec_mag;
               op_x_q         <= top_mag;
               y_sign_q       <= sec_sign;
               eff_add_q      <= load_eff_add;
               carry_q        <= 1'b0;
               res_q          <= '0;
               entry_active_q <= 1'b0;
            end
            ACT_COMMIT: begin
               mag_q[sec_idx]  <= res_full;
               sign_q[sec_idx] <= commit_sign;
               depth_q         <= depth_q - 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dau_serial_stack.sv
module tb_dau_serial_stack;
   import dau_serial_stack_pkg::*;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   cyc;
   int   first_cyc;
   int   acc_cyc;
   int   stray_err;
   logic acc_ready;

   logic [4:0] cap_q[$];
   logic       err_q[$];
   int         exp_q[$];

   dau_serial_stack_if #(.STACK_DEPTH(7)) bus ();

   dau_serial_stack #(.NUM_DIGITS(4), .STACK_DEPTH(7)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial stray_err = 0;
   always @(negedge clk) begin
      if (bus.o_symbol_valid === 1'b1) begin
         if (cap_q.size() == 0) first_cyc = cyc;
         cap_q.push_back(bus.o_symbol);
         err_q.push_back(bus.o_error);
      end else if (bus.o_error !== 1'b0) begin
         stray_err++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic do_op(input logic [4:0] sym, input bit wait_done);
      int g;
      cap_q.delete();
      err_q.delete();
      first_cyc = -1;
      g = 0;
      while (bus.o_ready !== 1'b1 && g < 200) begin
         @(posedge clk); #1; g++;
      end
      chk("ready_wait", g < 200, 1);
      bus.i_valid  = 1'b1;
      bus.i_symbol = sym;
      @(posedge clk); #1;
      acc_cyc      = cyc;
      acc_ready    = bus.o_ready;
      bus.i_valid  = 1'b0;
      bus.i_symbol = '0;
      if (wait_done) begin
         g = 0;
         while (bus.o_ready !== 1'b1 && g < 200) begin
            @(posedge clk); #1; g++;
         end
         chk("done_wait", g < 200, 1);
      end
   endtask

   task automatic check_disp(input string tag);
      chk({tag, "/len"}, cap_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         chk($sformatf("%s/sym%0d", tag, i), cap_q[i], exp_q[i]);
         chk($sformatf("%s/err%0d", tag, i), err_q[i], (exp_q[i] == SYM_ERR));
      end
   endtask

   task automatic chk_lat(input string tag, input int expv);
      chk(tag, first_cyc - acc_cyc + 1, expv);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.i_valid  = 1'b0;
      bus.i_symbol = '0;
      first_cyc = -1;
      acc_cyc   = 0;
      acc_ready = 1'b0;

      #3;
      chk("rst_ready", bus.o_ready, 1);
      chk("rst_valid", bus.o_symbol_valid, 0);
      chk("rst_symbol", bus.o_symbol, 0);
      chk("rst_depth", bus.o_depth, 0);
      chk("rst_error", bus.o_error, 0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // 12 ENTER 3 ADD -> 15
      do_op(5'd1, 1);
      exp_q = '{0, 0, 0, 1, SYM_EOL};
      check_disp("digit1");
      chk_lat("digit1_lat", 1);
      do_op(5'd2, 1);
      exp_q = '{0, 0, 1, 2, SYM_EOL};
      check_disp("digit12");
      do_op(SYM_ENTER, 1);
      do_op(5'd3, 1);
      exp_q = '{0, 0, 0, 3, SYM_EOL};
      check_disp("push3");
      chk("push3_depth", bus.o_depth, 2);
      do_op(SYM_ADD, 1);
      chk("add_ready_drop", acc_ready, 0);
      exp_q = '{0, 0, 1, 5, SYM_EOL};
      check_disp("add");
      chk_lat("add_lat", 5);
      chk("add_depth", bus.o_depth, 1);
      do_op(SYM_CLEAR, 1);
      exp_q = '{0, 0, 0, 0, SYM_EOL};
      check_disp("clear1");
      chk("clear1_depth", bus.o_depth, 0);

      // 3 ENTER 10 SUB -> -7 via RECOMP, then -7 - 2 -> -9
      do_op(5'd3, 1); do_op(SYM_ENTER, 1); do_op(5'd1, 1); do_op(5'd0, 1);
      do_op(SYM_SUB, 1);
      exp_q = '{SYM_NEG, 0, 0, 0, 7, SYM_EOL};
      check_disp("sub_recomp");
      chk_lat("sub_recomp_lat", 9);
      chk("sub_recomp_depth", bus.o_depth, 1);
      do_op(5'd2, 1);
      do_op(SYM_SUB, 1);
      exp_q = '{SYM_NEG, 0, 0, 0, 9, SYM_EOL};
      check_disp("neg_sub");
      chk_lat("neg_sub_lat", 5);
      chk("neg_sub_depth", bus.o_depth, 1);
      do_op(SYM_CLEAR, 1);

      // 5 - 5 -> positive zero
      do_op(5'd5, 1); do_op(SYM_ENTER, 1); do_op(5'd5, 1);
      do_op(SYM_SUB, 1);
      exp_q = '{0, 0, 0, 0, SYM_EOL};
      check_disp("zero_res");
      do_op(SYM_CLEAR, 1);

      // 9999 + 1 overflows, stack untouched
      do_op(5'd9, 1); do_op(5'd9, 1); do_op(5'd9, 1); do_op(5'd9, 1);
      do_op(SYM_ENTER, 1); do_op(5'd1, 1);
      do_op(SYM_ADD, 1);
      exp_q = '{SYM_ERR, SYM_EOL};
      check_disp("ovf");
      chk_lat("ovf_lat", 5);
      chk("ovf_depth", bus.o_depth, 2);
      do_op(SYM_DROP, 1);
      exp_q = '{9, 9, 9, 9, SYM_EOL};
      check_disp("ovf_drop");
      chk("ovf_drop_depth", bus.o_depth, 1);
      do_op(SYM_CLEAR, 1);

      // Stack full, then underflow cases
      for (int d = 1; d <= 7; d++) begin
         do_op(5'(d), 1);
         do_op(SYM_ENTER, 1);
      end
      chk("full_depth", bus.o_depth, 7);
      do_op(5'd5, 1);
      exp_q = '{SYM_ERR, SYM_EOL};
      check_disp("push_full");
      chk_lat("push_full_lat", 1);
      chk("push_full_depth", bus.o_depth, 7);
      do_op(SYM_CLEAR, 1);
      do_op(5'd1, 1); do_op(SYM_ENTER, 1);
      do_op(SYM_ADD, 1);
      exp_q = '{SYM_ERR, SYM_EOL};
      check_disp("add_one");
      chk("add_one_depth", bus.o_depth, 1);
      do_op(SYM_CLEAR, 1);
      do_op(SYM_DROP, 1);
      exp_q = '{SYM_ERR, SYM_EOL};
      check_disp("drop_empty");
      chk("drop_empty_depth", bus.o_depth, 0);

      // Fifth digit ignored, SWAP, CLEAR
      do_op(5'd1, 1); do_op(5'd2, 1); do_op(5'd3, 1); do_op(5'd4, 1);
      do_op(5'd5, 1);
      exp_q = '{1, 2, 3, 4, SYM_EOL};
      check_disp("digit5");
      chk("digit5_depth", bus.o_depth, 1);
      do_op(SYM_ENTER, 1); do_op(5'd6, 1);
      do_op(SYM_SWAP, 1);
      exp_q = '{1, 2, 3, 4, SYM_EOL};
      check_disp("swap");
      do_op(SYM_DROP, 1);
      exp_q = '{0, 0, 0, 6, SYM_EOL};
      check_disp("swap_drop");
      do_op(SYM_CLEAR, 1);
      exp_q = '{0, 0, 0, 0, SYM_EOL};
      check_disp("clear2");
      chk("clear2_depth", bus.o_depth, 0);

      // Unknown code: swallowed silently
      do_op(5'd20, 1);
      chk("unknown_len", cap_q.size(), 0);
      chk("unknown_ready", acc_ready, 1);

      // Reset during EXEC of a SUB
      do_op(5'd3, 1); do_op(SYM_ENTER, 1); do_op(5'd1, 1); do_op(5'd0, 1);
      do_op(SYM_SUB, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      cap_q.delete();
      err_q.delete();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", bus.o_symbol_valid, 0);
      chk("mid_rst_ready", bus.o_ready, 1);
      chk("mid_rst_depth", bus.o_depth, 0);
      repeat (5) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("post_rst_quiet", cap_q.size(), 0);
      chk("post_rst_ready", bus.o_ready, 1);
      chk("post_rst_depth", bus.o_depth, 0);
      do_op(5'd4, 1);
      exp_q = '{0, 0, 0, 4, SYM_EOL};
      check_disp("post_rst_digit");

      chk("stray_error", stray_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
